// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// spi_pkg : shared SPI master types, mode constants and parameter defaults
// Rev 1.0
// ============================================================================
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } spi_state_e;

    localparam logic c_spi_cpol = 1'b0;
    localparam logic c_spi_cpha = 1'b0;

    localparam int c_def_data_w = 8;
    localparam int c_def_div    = 10;
    localparam int c_def_cs_gap = 2;

endpackage
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================================
// spi_sclk_gen : half-period counter and SPI clock toggle with edge strobes
// Rev 1.0
// ============================================================================
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int DIV = c_def_div
)
(
    input  logic m_clk,
    input  logic rst,
    input  logic enable_i,
    input  logic clear_i,
    input  logic toggle_i,
    output logic spi_clk_o,
    output logic half_evt_o,
    output logic rise_evt_o,
    output logic fall_evt_o
);

    localparam int                 c_cnt_w    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DIV - 1);

    logic [c_cnt_w-1:0] hcnt_q;
    logic [c_cnt_w-1:0] hcnt_d;
    logic               sclk_q;
    logic               sclk_d;
    logic               w_half_evt;

    assign w_half_evt = enable_i && !clear_i && (hcnt_q == c_cnt_last);

    always_comb begin
        hcnt_d = hcnt_q;
        sclk_d = sclk_q;
        if (clear_i) begin
            hcnt_d = '0;
            sclk_d = c_spi_cpol;
        end else if (enable_i) begin
            hcnt_d = w_half_evt ? '0 : hcnt_q + 1'b1;
            // The clock only moves while toggling is allowed; SETUP/HOLD just time out.
            if (w_half_evt && toggle_i) begin
                sclk_d = ~sclk_q;
            end
        end
    end

    always_ff @(posedge m_clk) begin
        if (rst) begin
            hcnt_q <= '0;
            sclk_q <= c_spi_cpol;
        end else begin
            hcnt_q <= hcnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign spi_clk_o  = sclk_q;
    assign half_evt_o = w_half_evt;
    assign rise_evt_o = w_half_evt && toggle_i && (sclk_q == c_spi_cpol);
    assign fall_evt_o = w_half_evt && toggle_i && (sclk_q != c_spi_cpol);

endmodule
`default_nettype wire

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// spi_master_ctrl : single-word mode-0 SPI master (CS setup, clocking, hold, gap)
// Rev 1.0
// ============================================================================
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W = c_def_data_w,
    parameter int DIV    = c_def_div,
    parameter int CS_GAP = c_def_cs_gap
)
(
    input  logic              m_clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              spi_cs,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int                 c_bit_w    = $clog2(DATA_W + 1);
    localparam int                 c_gap_w    = $clog2(CS_GAP + 1);
    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(DATA_W);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(CS_GAP - 1);

    spi_state_e          state_q;
    spi_state_e          state_d;
    logic [DATA_W-1:0]   tx_sh_q;
    logic [DATA_W-1:0]   tx_sh_d;
    logic [DATA_W-1:0]   rx_sh_q;
    logic [DATA_W-1:0]   rx_sh_d;
    logic [c_bit_w-1:0]  bit_cnt_q;
    logic [c_bit_w-1:0]  bit_cnt_d;
    logic [c_gap_w-1:0]  gap_cnt_q;
    logic [c_gap_w-1:0]  gap_cnt_d;
    logic                cs_q;
    logic                cs_d;
    logic                mosi_q;
    logic                mosi_d;
    logic [DATA_W-1:0]   rx_data_q;
    logic [DATA_W-1:0]   rx_data_d;
    logic                rx_valid_q;
    logic                rx_valid_d;

    logic                w_gen_en;
    logic                w_gen_clr;
    logic                w_gen_tog;
    logic                w_half_evt;
    logic                w_rise_evt;
    logic                w_fall_evt;
    logic                w_sclk;

    assign w_gen_clr = (state_q == IDLE);
    assign w_gen_en  = (state_q == SETUP) || (state_q == XFER) || (state_q == HOLD);
    assign w_gen_tog = (state_q == XFER);

    spi_sclk_gen #(
        .DIV (DIV)
    ) u_sclk_gen (
        .m_clk      (m_clk),
        .rst        (rst),
        .enable_i   (w_gen_en),
        .clear_i    (w_gen_clr),
        .toggle_i   (w_gen_tog),
        .spi_clk_o  (w_sclk),
        .half_evt_o (w_half_evt),
        .rise_evt_o (w_rise_evt),
        .fall_evt_o (w_fall_evt)
    );

    always_comb begin
        state_d    = state_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        cs_d       = cs_q;
        mosi_d     = mosi_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    tx_sh_d   = tx_data;
                    rx_sh_d   = '0;
                    bit_cnt_d = '0;
                    cs_d      = 1'b0;
                    mosi_d    = tx_data[DATA_W-1];
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (w_half_evt) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (w_rise_evt) begin
                    rx_sh_d   = DATA_W'({rx_sh_q, spi_miso});
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                // The falling edge after the final sample closes the clocking phase.
                if (w_fall_evt) begin
                    if (bit_cnt_q == c_bit_last) begin
                        state_d = HOLD;
                    end else begin
                        tx_sh_d = tx_sh_q << 1;
                        mosi_d  = tx_sh_d[DATA_W-1];
                    end
                end
            end
            HOLD: begin
                if (w_half_evt) begin
                    cs_d       = 1'b1;
                    mosi_d     = 1'b0;
                    rx_data_d  = rx_sh_q;
                    rx_valid_d = 1'b1;
                    gap_cnt_d  = '0;
                    state_d    = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q == c_gap_last) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                cs_d    = 1'b1;
                mosi_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge m_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            cs_q       <= cs_d;
            mosi_q     <= mosi_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign tx_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign spi_cs   = cs_q;
    assign spi_clk  = w_sclk;
    assign spi_mosi = mosi_q;

endmodule
`default_nettype wire
